// File: rtl/rr_mux_arb_2to1.sv
// Two-input packet-aware round-robin stream arbiter with a registered output slice.
// Picks which of w0/w1 owns the output, locks that owner for a multi-beat packet,
// and drives the 2:1 select s aligned with each registered output beat.
module rr_mux_arb_2to1 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic [WIDTH-1:0] w0_data,
  input  logic             w0_valid,
  input  logic             w0_last,
  output logic             w0_ready,

  input  logic [WIDTH-1:0] w1_data,
  input  logic             w1_valid,
  input  logic             w1_last,
  output logic             w1_ready,

  output logic [WIDTH-1:0] f_data,
  output logic             f_valid,
  output logic             f_last,
  input  logic             f_ready,

  output logic             s
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLock0 = 2'b01,
    StLock1 = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;

  logic [WIDTH-1:0] f_data_q, f_data_d;
  logic             f_valid_q, f_valid_d;
  logic             f_last_q, f_last_d;
  logic             s_q, s_d;

  logic             grant_vld;
  logic             grant_idx;
  logic             load_en;
  logic             sel_valid;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             in_xfer;

  // Output slice can take a new beat when it is empty or its beat leaves this cycle.
  assign load_en = ~f_valid_q | f_ready;

  // Grant selection: valids only matter while idle; a lock ignores the other source.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (w0_valid && w1_valid) begin
          grant_vld = 1'b1;
          grant_idx = ptr_q;
        end else if (w0_valid) begin
          grant_vld = 1'b1;
          grant_idx = 1'b0;
        end else if (w1_valid) begin
          grant_vld = 1'b1;
          grant_idx = 1'b1;
        end
      end
      StLock0: begin
        grant_vld = 1'b1;
        grant_idx = 1'b0;
      end
      StLock1: begin
        grant_vld = 1'b1;
        grant_idx = 1'b1;
      end
      default: begin
        grant_vld = 1'b0;
        grant_idx = 1'b0;
      end
    endcase
  end

  assign w0_ready = grant_vld & ~grant_idx & load_en;
  assign w1_ready = grant_vld &  grant_idx & load_en;

  // Route the granted source into the output slice.
  always_comb begin
    sel_valid = grant_idx ? w1_valid : w0_valid;
    sel_data  = grant_idx ? w1_data  : w0_data;
    sel_last  = grant_idx ? w1_last  : w0_last;
  end

  assign in_xfer = grant_vld & load_en & sel_valid;

  // Next-state: output slice, lock FSM and round-robin pointer all move on input transfers.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    f_data_d  = f_data_q;
    f_valid_d = f_valid_q;
    f_last_d  = f_last_q;
    s_d       = s_q;

    // Slice drains when it can load but nothing arrives; payload fields keep their value.
    if (load_en) begin
      f_valid_d = 1'b0;
    end

    if (in_xfer) begin
      f_valid_d = 1'b1;
      f_data_d  = sel_data;
      f_last_d  = sel_last;
      s_d       = grant_idx;
      if (sel_last) begin
        state_d = StIdle;
        // Hand priority to the other source once a packet completes.
        ptr_d   = ~grant_idx;
      end else begin
        state_d = grant_idx ? StLock1 : StLock0;
      end
    end
  end

  // All state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      f_data_q  <= '0;
      f_valid_q <= 1'b0;
      f_last_q  <= 1'b0;
      s_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      f_data_q  <= f_data_d;
      f_valid_q <= f_valid_d;
      f_last_q  <= f_last_d;
      s_q       <= s_d;
    end
  end

  assign f_data  = f_data_q;
  assign f_valid = f_valid_q;
  assign f_last  = f_last_q;
  assign s       = s_q;

endmodule

// File: tb/tb_rr_mux_arb_2to1.sv
// Bench for rr_mux_arb_2to1: directed scenarios plus randomized traffic against a
// packet-level reference model (owner of current packet, priority, held output beat).
module tb_rr_mux_arb_2to1;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] w0_data, w1_data;
  logic         w0_valid, w1_valid, w0_last, w1_last;
  logic         w0_ready, w1_ready;
  logic [W-1:0] f_data;
  logic         f_valid, f_last, f_ready, s;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           m_owner;  // -1 when no packet is in progress, else owning source
  int           m_ptr;    // preferred source on a tie
  bit           m_v;
  logic [W-1:0] m_d;
  bit           m_l;
  bit           m_s;

  rr_mux_arb_2to1 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w0_data  (w0_data),
    .w0_valid (w0_valid),
    .w0_last  (w0_last),
    .w0_ready (w0_ready),
    .w1_data  (w1_data),
    .w1_valid (w1_valid),
    .w1_last  (w1_last),
    .w1_ready (w1_ready),
    .f_data   (f_data),
    .f_valid  (f_valid),
    .f_last   (f_last),
    .f_ready  (f_ready),
    .s        (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_grant();
    if (m_owner >= 0) return m_owner;
    if (w0_valid && w1_valid) return m_ptr;
    if (w0_valid) return 0;
    if (w1_valid) return 1;
    return -1;
  endfunction

  function automatic bit m_load();
    return !m_v || f_ready;
  endfunction

  task automatic drive(input bit v0, input logic [W-1:0] d0, input bit l0,
                       input bit v1, input logic [W-1:0] d1, input bit l1, input bit fr);
    w0_valid = v0; w0_data = d0; w0_last = l0;
    w1_valid = v1; w1_data = d1; w1_last = l1;
    f_ready  = fr;
    #1;
  endtask

  // Advance model with the inputs present before the edge, then step the clock.
  task automatic tick();
    int g;
    bit ld;
    bit vg;
    g  = m_grant();
    ld = m_load();
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_v = 0; m_d = '0; m_l = 0; m_s = 0;
    end else if (ld) begin
      vg = (g == 0) ? w0_valid : (g == 1) ? w1_valid : 1'b0;
      if (g >= 0 && vg) begin
        m_v = 1;
        m_d = (g == 1) ? w1_data : w0_data;
        m_l = (g == 1) ? w1_last : w0_last;
        m_s = (g == 1);
        if (m_l) begin
          m_owner = -1;
          m_ptr   = 1 - g;
        end else begin
          m_owner = g;
        end
      end else begin
        m_v = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    checks += 6;
    if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid got %0b want 0", f_valid); end
    if (f_data !== 8'h00) begin errors++; $display("FAIL reset_f_data got %h want 00", f_data); end
    if (f_last !== 1'b0) begin errors++; $display("FAIL reset_f_last got %0b want 0", f_last); end
    if (s !== 1'b0) begin errors++; $display("FAIL reset_s got %0b want 0", s); end
    if (w0_ready !== 1'b0) begin errors++; $display("FAIL reset_w0_ready got %0b want 0", w0_ready); end
    if (w1_ready !== 1'b0) begin errors++; $display("FAIL reset_w1_ready got %0b want 0", w1_ready); end
  endtask

  task automatic test_single_beat();
    drive(1, 8'h11, 1, 0, 8'h00, 0, 1);
    checks += 2;
    if (w0_ready !== 1'b1) begin errors++; $display("FAIL single_w0_ready got %0b want 1", w0_ready); end
    if (w1_ready !== 1'b0) begin errors++; $display("FAIL single_w1_ready got %0b want 0", w1_ready); end
    tick();
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    checks += 4;
    if (f_valid !== 1'b1) begin errors++; $display("FAIL single_f_valid got %0b want 1", f_valid); end
    if (f_data !== 8'h11) begin errors++; $display("FAIL single_f_data got %h want 11", f_data); end
    if (f_last !== 1'b1) begin errors++; $display("FAIL single_f_last got %0b want 1", f_last); end
    if (s !== 1'b0) begin errors++; $display("FAIL single_s got %0b want 0", s); end
    tick();
  endtask

  task automatic test_alternate();
    logic [W-1:0] exp_d [4];
    bit           exp_s [4];
    logic [W-1:0] n0, n1;
    exp_d[0] = 8'hA0; exp_d[1] = 8'hB0; exp_d[2] = 8'hA1; exp_d[3] = 8'hB1;
    exp_s[0] = 0; exp_s[1] = 1; exp_s[2] = 0; exp_s[3] = 1;
    apply_reset();
    n0 = 0; n1 = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1, 8'hA0 + n0, 1, 1, 8'hB0 + n1, 1, 1);
      tick();
      checks += 2;
      if (f_data !== exp_d[k]) begin
        errors++; $display("FAIL alt_data[%0d] got %h want %h", k, f_data, exp_d[k]);
      end
      if (s !== exp_s[k]) begin
        errors++; $display("FAIL alt_s[%0d] got %0b want %0b", k, s, exp_s[k]);
      end
      if (k % 2 == 0) n0++; else n1++;
    end
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    tick();
  endtask

  task automatic test_packet_lock();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1, 8'h30 + k[7:0], (k == 2), 1, 8'h40, 1, 1);
      checks += 2;
      if (w0_ready !== 1'b1) begin errors++; $display("FAIL lock_w0_ready[%0d] got %0b want 1", k, w0_ready); end
      if (w1_ready !== 1'b0) begin errors++; $display("FAIL lock_w1_ready[%0d] got %0b want 0", k, w1_ready); end
      tick();
      checks += 3;
      if (f_data !== 8'h30 + k[7:0]) begin
        errors++; $display("FAIL lock_data[%0d] got %h want %h", k, f_data, 8'h30 + k[7:0]);
      end
      if (s !== 1'b0) begin errors++; $display("FAIL lock_s[%0d] got %0b want 0", k, s); end
      if (f_last !== (k == 2)) begin errors++; $display("FAIL lock_last[%0d] got %0b", k, f_last); end
    end
    drive(0, 8'h00, 0, 1, 8'h40, 1, 1);
    checks++;
    if (w1_ready !== 1'b1) begin errors++; $display("FAIL lock_release got %0b want 1", w1_ready); end
    tick();
    checks += 2;
    if (f_data !== 8'h40) begin errors++; $display("FAIL lock_w1_data got %h want 40", f_data); end
    if (s !== 1'b1) begin errors++; $display("FAIL lock_w1_s got %0b want 1", s); end
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    tick();
  endtask

  task automatic test_backpressure();
    apply_reset();
    drive(1, 8'h5C, 1, 0, 8'h00, 0, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 8'h5D, 1, 1, 8'h6D, 1, 0);
      checks += 5;
      if (w0_ready !== 1'b0 || w1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready[%0d] got %0b%0b want 00", k, w0_ready, w1_ready);
      end
      if (f_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0b want 1", k, f_valid); end
      if (f_data !== 8'h5C) begin errors++; $display("FAIL bp_data[%0d] got %h want 5c", k, f_data); end
      if (s !== 1'b0) begin errors++; $display("FAIL bp_s[%0d] got %0b want 0", k, s); end
      if (f_last !== 1'b1) begin errors++; $display("FAIL bp_last[%0d] got %0b want 1", k, f_last); end
      tick();
    end
    // Priority moved to w1 after the 0x5C beat, so w1 goes first on release.
    drive(1, 8'h5D, 1, 1, 8'h6D, 1, 1);
    checks++;
    if (w1_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_w1 got %0b want 1", w1_ready); end
    tick();
    checks += 2;
    if (f_data !== 8'h6D) begin errors++; $display("FAIL bp_out1 got %h want 6d", f_data); end
    if (s !== 1'b1) begin errors++; $display("FAIL bp_out1_s got %0b want 1", s); end
    drive(1, 8'h5D, 1, 0, 8'h00, 0, 1);
    tick();
    checks += 2;
    if (f_data !== 8'h5D) begin errors++; $display("FAIL bp_out2 got %h want 5d", f_data); end
    if (s !== 1'b0) begin errors++; $display("FAIL bp_out2_s got %0b want 0", s); end
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    tick();
    checks++;
    if (f_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", f_valid); end
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    drive(0, 8'h00, 0, 1, 8'h70, 0, 1);
    tick();
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 1, 8'h71, 0, 1);
    tick();
    rst_n = 1'b1;
    drive(1, 8'h80, 1, 1, 8'h71, 0, 1);
    checks += 4;
    if (f_valid !== 1'b0) begin errors++; $display("FAIL rmid_f_valid got %0b want 0", f_valid); end
    if (f_data !== 8'h00) begin errors++; $display("FAIL rmid_f_data got %h want 00", f_data); end
    if (w0_ready !== 1'b1) begin errors++; $display("FAIL rmid_w0_ready got %0b want 1", w0_ready); end
    if (w1_ready !== 1'b0) begin errors++; $display("FAIL rmid_w1_ready got %0b want 0", w1_ready); end
    tick();
    checks += 2;
    if (f_data !== 8'h80) begin errors++; $display("FAIL rmid_data got %h want 80", f_data); end
    if (s !== 1'b0) begin errors++; $display("FAIL rmid_s got %0b want 0", s); end
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    tick();
  endtask

  task automatic test_random();
    bit           v0, v1, l0, l1, fr, er0, er1;
    logic [W-1:0] d0, d1;
    int           g;
    int           bad;
    v0 = 0; v1 = 0; l0 = 0; l1 = 0; d0 = '0; d1 = '0;
    bad = 0;
    for (int k = 0; k < 600; k++) begin
      // A pending beat stays put until accepted; idle sources may start a new one.
      if (!v0) begin v0 = $urandom_range(0, 1); d0 = W'($urandom); l0 = ($urandom_range(0, 2) == 0); end
      if (!v1) begin v1 = $urandom_range(0, 1); d1 = W'($urandom); l1 = ($urandom_range(0, 2) == 0); end
      fr = ($urandom_range(0, 3) != 0);
      drive(v0, d0, l0, v1, d1, l1, fr);
      g   = m_grant();
      er0 = (g == 0) && m_load();
      er1 = (g == 1) && m_load();
      checks += 2;
      if (w0_ready !== er0) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rnd_w0_ready[%0d] got %0b want %0b", k, w0_ready, er0);
      end
      if (w1_ready !== er1) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rnd_w1_ready[%0d] got %0b want %0b", k, w1_ready, er1);
      end
      tick();
      if (er0 && v0) v0 = 0;
      if (er1 && v1) v1 = 0;
      checks += 4;
      if (f_valid !== m_v) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rnd_f_valid[%0d] got %0b want %0b", k, f_valid, m_v);
      end
      if (f_data !== m_d) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rnd_f_data[%0d] got %h want %h", k, f_data, m_d);
      end
      if (f_last !== m_l) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rnd_f_last[%0d] got %0b want %0b", k, f_last, m_l);
      end
      if (s !== m_s) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rnd_s[%0d] got %0b want %0b", k, s, m_s);
      end
    end
    drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    m_owner = -1; m_ptr = 0; m_v = 0; m_d = '0; m_l = 0; m_s = 0;
    w0_valid = 0; w1_valid = 0; w0_data = '0; w1_data = '0;
    w0_last = 0; w1_last = 0; f_ready = 1;
    test_reset();
    test_single_beat();
    test_alternate();
    test_packet_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
